vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
- Exports the raw scan coordinates PCol/PRow to the debug-display/text renderer.
- Takes that renderer's 12-bit pixel colour back as Din and drives registered, blank-masked R/G/B plus HS/VS to the connector.
- Sync and blanking are delayed by a parameterised pipeline depth so they line up with the renderer's font-ROM/register latency.

Parameters:
- PIPE_DLY, 2: cycles from a coordinate appearing on PCol/PRow to its colour being sampled from Din; legal range 1..7.
- FCNT_W, 16: width of the frame counter.

Ports:
- clk, input, 1: 25 MHz pixel clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- Din, input, 12: pixel colour; [3:0]=R, [7:4]=G, [11:8]=B.
- PCol, output, 10: horizontal counter, 0..799, registered.
- PRow, output, 10: vertical counter, 0..524, registered.
- R, output, 4: red; 0 outside the visible window.
- G, output, 4: green; 0 outside the visible window.
- B, output, 4: blue; 0 outside the visible window.
- HS, output, 1: horizontal sync, active-low pulse.
- VS, output, 1: vertical sync, active-low pulse.
- rdn, output, 1: active-low "visible pixel" flag, aligned with R/G/B.
- frame_tick, output, 1: one-cycle pulse at PCol==0 && PRow==0 (undelayed).
- frame_cnt, output, FCNT_W: count of completed frames; wraps.

Behaviour:
- Clock and reset: single clock domain on clk. rst_n is asynchronous, active-low; all flops clear immediately on assertion.
- Reset values: PCol=0, PRow=0, R=G=B=0, HS=0, VS=0, rdn=1, frame_tick=0, frame_cnt=0. Every delay-line stage resets to hs=0, vs=0, vis=0.
- Counters:
  - PCol increments each cycle; 799 wraps to 0.
  - PRow increments only in the cycle where PCol==799; 524 wraps to 0 on that same edge.
  - On release of reset the first edge gives PCol=1.
- Raw decode, combinational from current PCol/PRow:
  - hs_raw = (PCol > 95), i.e. low for 96 cycles per 800.
  - vs_raw = (PRow > 1), i.e. low for lines 0..1.
  - vis_raw = (PCol >= 143 && PCol <= 782 && PRow >= 35 && PRow <= 514).
  - Visible window is exactly 640x480, so the renderer's col_addr = PCol-143 and row_addr = PRow-35 land at 0..639 / 0..479.
- Delay line:
  - {hs_raw, vs_raw, vis_raw} pass through PIPE_DLY register stages.
  - HS = hs_d[PIPE_DLY] and VS = vs_d[PIPE_DLY], both registered outputs.
- Colour register: on each edge, if vis_d[PIPE_DLY-1] then {B,G,R} <= Din, else 0; rdn <= ~vis_d[PIPE_DLY-1].
- Alignment: Din sampled on edge N belongs to the coordinate present on PCol/PRow at edge N-PIPE_DLY+1. R/G/B, rdn, HS and VS all become valid together at edge N+1.
- frame_tick: registered. It is 1 for exactly one cycle, the cycle after the counters wrap to (0,0).
- frame_cnt: increments on that same edge; all-ones wraps to 0.
- Din outside the visible window is ignored; no X on Din propagates to R/G/B while rdn=1.
- Mid-frame reset: counters restart at (0,0) and the delay line is flushed. The first visible pixel after release therefore appears 143+35*800 cycles later, plus pipeline delay.
- No handshake back-pressure: Din must be valid every cycle while visible.

Decomposition:
- Shared package vga_pkg holds:
  - H_SYNC=96, H_VIS_START=143, H_VIS_END=782, H_TOTAL=800.
  - V_SYNC=2, V_VIS_START=35, V_VIS_END=514, V_TOTAL=525.
  - COL_W=10 and the Din field-slice constants.
- One sub-module, vga_sync_delay: a parameterised-depth shift register with async active-low reset, used for the {hs, vs, vis} bundle.

Test Plan:
- Reset release:
  - Stimulus: hold rst_n=0 for 5 cycles, then release.
  - Required: during reset all outputs are at their reset values; the first edge after release gives PCol=1, PRow=0.
- Horizontal timing:
  - Stimulus: run 3 lines, PIPE_DLY=2.
  - Required: HS low for exactly 96 cycles every 800; the HS falling edge lags the PCol 799→0 wrap by 2 cycles.
- Vertical and frame timing:
  - Stimulus: run 2 frames.
  - Required: VS low for exactly 1600 cycles every 420000; frame_tick pulses once per 420000 cycles; frame_cnt goes 0→1→2.
- Visible window and masking:
  - Stimulus: Din=12'hABC constant.
  - Required: per frame, exactly 307200 cycles with rdn=0, each showing R=4'hC, G=4'hB, B=4'hA; R=G=B=0 whenever rdn=1.
  - Required: first rdn=0 occurs PIPE_DLY cycles after PCol=143, PRow=35.
- Alignment:
  - Stimulus: Din driven as {2'b0, PCol} delayed PIPE_DLY-1 cycles, PIPE_DLY=3.
  - Required: the first visible pixel of each line has {B,G,R}=12'd143 and the last has 12'd782.
- Wrap and mid-frame reset:
  - Stimulus: preload frame_cnt to 16'hFFFF via a forced run, then complete one frame → frame_cnt=0.
  - Stimulus: assert rst_n at PCol=400, PRow=200.
  - Required: outputs return to reset values within the same cycle (asynchronous); no stale colour appears after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the 640x480@60 Hz timing generator.
//   - Horizontal/vertical timing points (counter values, 0-based).
//   - Din field slices for the 12-bit {B,G,R} pixel word.
//   - sync_t: the {hs, vs, vis} bundle carried through the alignment delay line.
package vga_pkg;

    localparam int COL_W       = 10;

    // Horizontal timing in pixel clocks: sync is low for PCol 0..H_SYNC-1.
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 143;
    localparam int H_VIS_END   = 782;
    localparam int H_TOTAL     = 800;

    // Vertical timing in lines: sync is low for PRow 0..V_SYNC-1.
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 514;
    localparam int V_TOTAL     = 525;

    // Din layout: [3:0]=R, [7:4]=G, [11:8]=B.
    localparam int DIN_W       = 12;
    localparam int CH_W        = 4;
    localparam int R_LSB       = 0;
    localparam int G_LSB       = 4;
    localparam int B_LSB       = 8;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam int SYNC_W = $bits(sync_t);

    // Inclusive range test on a counter value.
    function automatic logic in_range(input logic [COL_W-1:0] v, input int lo, input int hi);
        return (v >= COL_W'(lo)) && (v <= COL_W'(hi));
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register with asynchronous active-low reset.
//   clk, rst_n : clock / async active-low reset (all stages clear to 0)
//   din        : W-bit input, stage 0 (combinational)
//   q_pre      : stage DEPTH-1 (equals din when DEPTH==1)
//   q_out      : stage DEPTH (always a flop output)
module vga_sync_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] q_pre,
    output logic [W-1:0] q_out
);

    logic [DEPTH:1][W-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[1] <= din;
            for (int i = DEPTH; i > 1; i--) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_out = stage_q[DEPTH];

    // With a single stage the "one before last" tap is the raw input itself.
    generate
        if (DEPTH == 1) begin : g_d1
            assign q_pre = din;
        end else begin : g_dn
            assign q_pre = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA timing from a 25 MHz pixel clock.
//   clk, rst_n  : pixel clock / async active-low reset
//   Din         : renderer colour {B,G,R}, must be valid every visible cycle
//                 (no back-pressure exists; there is no valid/ready pair)
//   PCol, PRow  : registered scan counters exported to the renderer
//   R, G, B     : registered colour, forced to 0 outside the visible window
//   HS, VS      : active-low syncs, delayed PIPE_DLY cycles
//   rdn         : active-low visible flag, aligned with R/G/B
//   frame_tick  : one-cycle pulse while the counters read (0,0)
//   frame_cnt   : completed-frame count, wraps
// PIPE_DLY (1..7) is the renderer latency from a coordinate on PCol/PRow
// to its colour being presented on Din.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIPE_DLY = 2,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIN_W-1:0]  Din,
    output logic [COL_W-1:0]  PCol,
    output logic [COL_W-1:0]  PRow,
    output logic [CH_W-1:0]   R,
    output logic [CH_W-1:0]   G,
    output logic [CH_W-1:0]   B,
    output logic              HS,
    output logic              VS,
    output logic              rdn,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_cnt
);

    logic             col_wrap;
    logic             row_wrap;
    logic             frame_end;
    logic [COL_W-1:0] col_nxt;
    logic [COL_W-1:0] row_nxt;

    sync_t raw;
    sync_t d_pre;
    sync_t d_out;

    // ---------------- scan counters ----------------
    assign col_wrap  = (PCol == COL_W'(H_TOTAL - 1));
    assign row_wrap  = (PRow == COL_W'(V_TOTAL - 1));
    assign frame_end = col_wrap && row_wrap;

    always_comb begin
        col_nxt = col_wrap ? '0 : PCol + COL_W'(1);
        row_nxt = PRow;
        if (col_wrap) begin
            row_nxt = row_wrap ? '0 : PRow + COL_W'(1);
        end
    end

    // frame_tick registers the wrap condition, so it is high exactly while
    // the counters read (0,0); startup from reset does not count as a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCol       <= '0;
            PRow       <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            PCol       <= col_nxt;
            PRow       <= row_nxt;
            frame_tick <= frame_end;
            frame_cnt  <= frame_cnt + FCNT_W'(frame_end);
        end
    end

    // ---------------- raw decode ----------------
    always_comb begin
        raw     = '0;
        raw.hs  = (PCol >= COL_W'(H_SYNC));
        raw.vs  = (PRow >= COL_W'(V_SYNC));
        raw.vis = in_range(PCol, H_VIS_START, H_VIS_END) &&
                  in_range(PRow, V_VIS_START, V_VIS_END);
    end

    // ---------------- alignment delay ----------------
    vga_sync_delay #(
        .DEPTH (PIPE_DLY),
        .W     (SYNC_W)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (raw),
        .q_pre (d_pre),
        .q_out (d_out)
    );

    assign HS = d_out.hs;
    assign VS = d_out.vs;

    // Colour is registered from the stage before last so R/G/B/rdn land on
    // the same edge as HS/VS leaving the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R   <= '0;
            G   <= '0;
            B   <= '0;
            rdn <= 1'b1;
        end else begin
            rdn <= ~d_pre.vis;
            if (d_pre.vis) begin
                R <= Din[R_LSB +: CH_W];
                G <= Din[G_LSB +: CH_W];
                B <= Din[B_LSB +: CH_W];
            end else begin
                R <= '0;
                G <= '0;
                B <= '0;
            end
        end
    end

    // Taps that the output logic does not need.
    logic unused_taps;
    assign unused_taps = ^{d_pre.hs, d_pre.vs, d_out.vis};

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Two instances share clock and reset: dut_a (PIPE_DLY=2, constant Din=ABC)
// and dut_b (PIPE_DLY=3, Din = its own PCol delayed two cycles). Long spans
// of the frame are skipped by briefly forcing PRow.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] din_a;
    logic [11:0] din_b;

    logic [9:0]  pcol_a, prow_a, pcol_b, prow_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, rdn_a, tick_a;
    logic        hs_b, vs_b, rdn_b, tick_b;
    logic [15:0] fcnt_a, fcnt_b;

    always #20 clk = ~clk;

    vga_timing_gen #(.PIPE_DLY(2), .FCNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .Din(din_a),
        .PCol(pcol_a), .PRow(prow_a), .R(r_a), .G(g_a), .B(b_a),
        .HS(hs_a), .VS(vs_a), .rdn(rdn_a),
        .frame_tick(tick_a), .frame_cnt(fcnt_a)
    );

    vga_timing_gen #(.PIPE_DLY(3), .FCNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .Din(din_b),
        .PCol(pcol_b), .PRow(prow_b), .R(r_b), .G(g_b), .B(b_b),
        .HS(hs_b), .VS(vs_b), .rdn(rdn_b),
        .frame_tick(tick_b), .frame_cnt(fcnt_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // per-window observation counters
    int          c_vis, c_vis_b, c_bad_col, c_bad_mask;
    int          c_hs_low, c_vs_low, c_tick, c_first_b;
    logic [11:0] first_b, last_b;
    logic        prev_rdn_b;
    logic [11:0] prev_rgb_b;
    logic [9:0]  h0, h1, h2;
    logic [9:0]  force_row;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        c_vis = 0; c_vis_b = 0; c_bad_col = 0; c_bad_mask = 0;
        c_hs_low = 0; c_vs_low = 0; c_tick = 0; c_first_b = 0;
        first_b = '0; last_b = '0;
    endtask

    // One clock: sample #1 after the edge, then update the renderer model
    // for dut_b and the window counters.
    task automatic step();
        logic [11:0] rgb_b;
        @(posedge clk);
        #1;
        h2 = h1; h1 = h0; h0 = pcol_b;
        din_b = {2'b00, h2};
        rgb_b = {b_b, g_b, r_b};
        if (!rdn_a) begin
            c_vis++;
            if ({b_a, g_a, r_a} !== 12'hABC) c_bad_col++;
        end else if ({b_a, g_a, r_a} !== 12'h000) begin
            c_bad_mask++;
        end
        if (!rdn_b) c_vis_b++;
        else if (rgb_b !== 12'h000) c_bad_mask++;
        if (!hs_a) c_hs_low++;
        if (!vs_a) c_vs_low++;
        if (tick_a) c_tick++;
        if (prev_rdn_b && !rdn_b) begin
            c_first_b++;
            first_b = rgb_b;
        end
        if (!prev_rdn_b && rdn_b) last_b = prev_rgb_b;
        prev_rdn_b = rdn_b;
        prev_rgb_b = rgb_b;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_rc(input int col, input int row, input int budget, input string tag);
        int   k = 0;
        logic found;
        while (!(pcol_a == 10'(col) && prow_a == 10'(row)) && k < budget) begin
            step();
            k++;
        end
        found = (pcol_a == 10'(col) && prow_a == 10'(row));
        chk(tag, 32'(found), 32'd1);
    endtask

    // Hold PRow of both instances at v across one edge, then let go.
    task automatic force_rows(input logic [9:0] v);
        force_row = v;
        force dut_a.PRow = force_row;
        force dut_b.PRow = force_row;
        step();
        release dut_a.PRow;
        release dut_b.PRow;
    endtask

    initial begin
        rst_n = 1'b0;
        din_a = 12'hABC;
        din_b = '0;
        h0 = '0; h1 = '0; h2 = '0;
        force_row  = '0;
        prev_rdn_b = 1'b1;
        prev_rgb_b = '0;
        clear_counts();

        // ---- reset ----
        run(5);
        chk("rst_pcol", 32'(pcol_a), 32'd0);
        chk("rst_prow", 32'(prow_a), 32'd0);
        chk("rst_rgb", 32'({b_a, g_a, r_a}), 32'd0);
        chk("rst_hs", 32'(hs_a), 32'd0);
        chk("rst_vs", 32'(vs_a), 32'd0);
        chk("rst_rdn", 32'(rdn_a), 32'd1);
        chk("rst_tick", 32'(tick_a), 32'd0);
        chk("rst_fcnt", 32'(fcnt_a), 32'd0);
        chk("rst_rdn_b", 32'(rdn_b), 32'd1);

        rst_n = 1'b1;
        step();
        chk("rel_pcol", 32'(pcol_a), 32'd1);
        chk("rel_prow", 32'(prow_a), 32'd0);
        chk("rel_pcol_b", 32'(pcol_b), 32'd1);

        // ---- horizontal: HS falls 2 cycles after the 799->0 wrap ----
        wait_rc(0, 1, 900, "wait_line1");
        step();
        chk("hs_lag1", 32'(hs_a), 32'd1);
        step();
        chk("hs_lag2", 32'(hs_a), 32'd0);
        for (int l = 0; l < 3; l++) begin
            clear_counts();
            run(800);
            chk("hs_low_per_line", 32'(c_hs_low), 32'd96);
            chk("hs_period", 32'(hs_a), 32'd0);
        end

        // ---- frame wrap with frame_cnt preloaded to all-ones on dut_a ----
        force dut_a.frame_cnt = 16'hFFFF;
        force_rows(10'd523);
        release dut_a.frame_cnt;
        chk("fcnt_preload", 32'(fcnt_a), 32'hFFFF);
        wait_rc(0, 0, 2000, "wait_wrap1");
        chk("tick_a_wrap1", 32'(tick_a), 32'd1);
        chk("tick_b_wrap1", 32'(tick_b), 32'd1);
        chk("fcnt_a_wrap", 32'(fcnt_a), 32'd0);
        chk("fcnt_b_1", 32'(fcnt_b), 32'd1);
        chk("vs_at_wrap", 32'(vs_a), 32'd1);
        clear_counts();
        run(1700);
        chk("vs_low_len", 32'(c_vs_low), 32'd1600);
        chk("tick_once", 32'(c_tick), 32'd0);
        chk("vs_high_after", 32'(vs_a), 32'd1);

        // ---- visible window start ----
        clear_counts();
        force_rows(10'd34);
        wait_rc(143, 35, 1000, "wait_vis_start");
        chk("row34_dark_a", 32'(c_vis), 32'd0);
        chk("row34_dark_b", 32'(c_vis_b), 32'd0);
        step();
        chk("vis_lat_m1", 32'(rdn_a), 32'd1);
        step();
        chk("vis_lat", 32'(rdn_a), 32'd0);
        chk("first_r", 32'(r_a), 32'hC);
        chk("first_g", 32'(g_a), 32'hB);
        chk("first_b", 32'(b_a), 32'hA);
        for (int l = 0; l < 2; l++) begin
            clear_counts();
            run(800);
            chk("vis_per_line", 32'(c_vis), 32'd640);
            chk("vis_colour", 32'(c_bad_col), 32'd0);
            chk("blank_mask", 32'(c_bad_mask), 32'd0);
            chk("align_edges", 32'(c_first_b), 32'd1);
            chk("align_first", 32'(first_b), 32'd143);
            chk("align_last", 32'(last_b), 32'd782);
        end

        // ---- visible window end (rows 513, 514, then dark 515) ----
        force_rows(10'd512);
        wait_rc(0, 513, 1000, "wait_row513");
        for (int l = 0; l < 2; l++) begin
            clear_counts();
            run(800);
            chk("vis_end_line", 32'(c_vis), 32'd640);
            chk("vis_end_mask", 32'(c_bad_mask), 32'd0);
            chk("align_end_first", 32'(first_b), 32'd143);
            chk("align_end_last", 32'(last_b), 32'd782);
        end
        clear_counts();
        run(800);
        chk("row515_dark_a", 32'(c_vis), 32'd0);
        chk("row515_dark_b", 32'(c_vis_b), 32'd0);

        // ---- second wrap ----
        force_rows(10'd523);
        wait_rc(0, 0, 2000, "wait_wrap2");
        chk("tick_a_wrap2", 32'(tick_a), 32'd1);
        chk("fcnt_a_1", 32'(fcnt_a), 32'd1);
        chk("fcnt_b_2", 32'(fcnt_b), 32'd2);

        // ---- mid-frame asynchronous reset at (400,200) ----
        force_rows(10'd199);
        wait_rc(400, 200, 1500, "wait_400_200");
        chk("pre_rst_rdn", 32'(rdn_a), 32'd0);
        chk("pre_rst_rgb", 32'({b_a, g_a, r_a}), 32'hABC);
        rst_n = 1'b0;
        #1;
        chk("arst_pcol", 32'(pcol_a), 32'd0);
        chk("arst_prow", 32'(prow_a), 32'd0);
        chk("arst_rgb", 32'({b_a, g_a, r_a}), 32'd0);
        chk("arst_rdn", 32'(rdn_a), 32'd1);
        chk("arst_hs", 32'(hs_a), 32'd0);
        chk("arst_vs", 32'(vs_a), 32'd0);
        chk("arst_fcnt", 32'(fcnt_a), 32'd0);
        chk("arst_rdn_b", 32'(rdn_b), 32'd1);
        chk("arst_rgb_b", 32'({b_b, g_b, r_b}), 32'd0);
        run(3);
        rst_n = 1'b1;
        clear_counts();
        step();
        chk("rel2_pcol", 32'(pcol_a), 32'd1);
        chk("rel2_prow", 32'(prow_a), 32'd0);
        run(300);
        chk("no_stale_a", 32'(c_vis), 32'd0);
        chk("no_stale_b", 32'(c_vis_b), 32'd0);
        chk("no_stale_rgb", 32'(c_bad_mask), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
